// File: rtl/regfile_write_queue.sv
// Buffered secondary writer for the register file write port: queues slow-producer
// writes, drains them when the primary writer is idle, and forwards pending values.
module regfile_write_queue #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [XLEN-1:0]          in_data,
  input  logic                     prio_we,
  input  logic [ADDR_W-1:0]        prio_addr,
  output logic [ADDR_W-1:0]        a3,
  output logic [XLEN-1:0]          di3,
  output logic                     we3,
  input  logic [ADDR_W-1:0]        q_a1,
  input  logic [ADDR_W-1:0]        q_a2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [XLEN-1:0]          fwd_data1,
  output logic [XLEN-1:0]          fwd_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [XLEN-1:0]   data_q [DEPTH];
  logic [XLEN-1:0]   data_d [DEPTH];
  logic [DEPTH-1:0]  live_q, live_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic push, pop, head_live;

  always_comb begin
    empty     = (count_q == '0);
    in_ready  = (count_q < CNT_W'(DEPTH));
    head_live = !empty && live_q[head_q];
    we3       = head_live && !prio_we;
    // Dead heads retire regardless of the primary writer; live heads only when it is idle.
    pop       = !empty && (!live_q[head_q] || !prio_we);
    push      = in_valid && in_ready && (in_addr != '0);
    a3        = empty ? '0 : addr_q[head_q];
    di3       = empty ? '0 : data_q[head_q];
    count     = count_q;
  end

  // Scan oldest to youngest so the last match wins (youngest data forwarded).
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    idx       = head_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if (live_q[idx] && (q_a1 != '0) && (addr_q[idx] == q_a1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = data_q[idx];
      end
      if (live_q[idx] && (q_a2 != '0) && (addr_q[idx] == q_a2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = data_q[idx];
      end
    end
  end

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    live_d  = live_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (prio_we && (prio_addr != '0)) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (live_q[i] && (addr_q[i] == prio_addr)) live_d[i] = 1'b0;
      end
    end
    if (pop) begin
      live_d[head_q] = 1'b0;
      head_d         = head_q + PTR_W'(1);
    end
    // Applied after the kill so a same-edge enqueue to prio_addr stays live.
    if (push) begin
      addr_d[tail_q] = in_addr;
      data_d[tail_q] = in_data;
      live_d[tail_q] = 1'b1;
      tail_d         = tail_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      live_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      live_q  <= live_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Self-checking bench for regfile_write_queue: directed scenarios plus randomized
// traffic against a queue-of-structs reference model.
module tb_regfile_write_queue;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [XLEN-1:0]   in_data;
  logic              prio_we;
  logic [ADDR_W-1:0] prio_addr;
  logic [ADDR_W-1:0] a3;
  logic [XLEN-1:0]   di3;
  logic              we3;
  logic [ADDR_W-1:0] q_a1, q_a2;
  logic              fwd_hit1, fwd_hit2;
  logic [XLEN-1:0]   fwd_data1, fwd_data2;
  logic [2:0]        count;
  logic              empty;

  int tests  = 0;
  int failed = 0;

  regfile_write_queue #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .prio_we(prio_we), .prio_addr(prio_addr),
    .a3(a3), .di3(di3), .we3(we3),
    .q_a1(q_a1), .q_a2(q_a2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  // Reference model: pending writes in program order, oldest at index 0.
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;
    bit                live;
  } ent_t;
  ent_t mq[$];

  logic              e_we3, e_ready, e_empty, e_hit1, e_hit2;
  logic [ADDR_W-1:0] e_a3;
  logic [XLEN-1:0]   e_di3, e_d1, e_d2;
  logic [2:0]        e_count;

  task automatic model_outs();
    e_count = 3'(mq.size());
    e_empty = (mq.size() == 0);
    e_ready = (mq.size() < DEPTH);
    e_we3 = 1'b0; e_a3 = '0; e_di3 = '0;
    if (mq.size() > 0) begin
      e_a3  = mq[0].addr;
      e_di3 = mq[0].data;
      e_we3 = mq[0].live && !prio_we;
    end
    e_hit1 = 1'b0; e_d1 = '0; e_hit2 = 1'b0; e_d2 = '0;
    foreach (mq[i]) begin
      if (mq[i].live && q_a1 != 0 && mq[i].addr == q_a1) begin e_hit1 = 1'b1; e_d1 = mq[i].data; end
      if (mq[i].live && q_a2 != 0 && mq[i].addr == q_a2) begin e_hit2 = 1'b1; e_d2 = mq[i].data; end
    end
  endtask

  task automatic model_edge();
    bit do_push, do_pop;
    ent_t e;
    do_push = in_valid && (mq.size() < DEPTH) && (in_addr != 0);
    do_pop  = (mq.size() > 0) && (!mq[0].live || !prio_we);
    if (prio_we && prio_addr != 0)
      foreach (mq[i]) if (mq[i].addr == prio_addr) mq[i].live = 0;
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      e.addr = in_addr; e.data = in_data; e.live = 1;
      mq.push_back(e);
    end
  endtask

  // Advance one clock: model follows the DUT edge, return at the following negedge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_addr = '0; in_data = '0;
    prio_we = 0; prio_addr = '0; q_a1 = '0; q_a2 = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    mq.delete();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    mq.delete();
    #1;
    tests++; if ({we3, empty, in_ready, count} !== {1'b0, 1'b1, 1'b1, 3'd0}) begin
      failed++; $display("FAIL reset_ctrl: got we3=%b empty=%b rdy=%b cnt=%0d need 0 1 1 0", we3, empty, in_ready, count); end
    tests++; if ({fwd_hit1, fwd_hit2, a3, di3} !== '0) begin
      failed++; $display("FAIL reset_data: got hit=%b%b a3=%0d di3=%0h need all 0", fwd_hit1, fwd_hit2, a3, di3); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_latency();
    in_valid = 1; in_addr = 5'd1; in_data = 32'd69; prio_we = 0;
    cyc();
    in_valid = 0;
    #1;
    tests++; if ({we3, a3, di3} !== {1'b1, 5'd1, 32'd69}) begin
      failed++; $display("FAIL lat_drive: got we3=%b a3=%0d di3=%0d need 1 1 69", we3, a3, di3); end
    cyc();
    #1;
    tests++; if ({empty, we3} !== 2'b10) begin
      failed++; $display("FAIL lat_retire: got empty=%b we3=%b need 1 0", empty, we3); end
  endtask

  task automatic test_fill_order();
    logic [ADDR_W-1:0] ea [4];
    logic [XLEN-1:0]   ed [4];
    ea = '{5'd3, 5'd5, 5'd3, 5'd7};
    ed = '{32'd10, 32'd20, 32'd30, 32'd40};
    prio_we = 1; prio_addr = '0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_addr = ea[i]; in_data = ed[i];
      cyc();
    end
    in_valid = 0; q_a1 = 5'd3; q_a2 = 5'd5;
    #1;
    tests++; if ({in_ready, count, we3} !== {1'b0, 3'd4, 1'b0}) begin
      failed++; $display("FAIL fill_full: got rdy=%b cnt=%0d we3=%b need 0 4 0", in_ready, count, we3); end
    tests++; if ({fwd_hit1, fwd_data1, fwd_hit2, fwd_data2} !== {1'b1, 32'd30, 1'b1, 32'd20}) begin
      failed++; $display("FAIL fill_fwd: got %b/%0d %b/%0d need 1/30 1/20", fwd_hit1, fwd_data1, fwd_hit2, fwd_data2); end
    prio_we = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if ({we3, a3, di3} !== {1'b1, ea[i], ed[i]}) begin
        failed++; $display("FAIL drain_%0d: got we3=%b a3=%0d di3=%0d need 1 %0d %0d", i, we3, a3, di3, ea[i], ed[i]); end
      cyc();
    end
    q_a1 = '0; q_a2 = '0;
    #1;
    tests++; if ({empty, we3} !== 2'b10) begin
      failed++; $display("FAIL drain_empty: got empty=%b we3=%b need 1 0", empty, we3); end
  endtask

  task automatic test_kill();
    prio_we = 1; prio_addr = '0;
    in_valid = 1; in_addr = 5'd5; in_data = 32'd20;
    cyc();
    in_valid = 0; prio_addr = 5'd5;
    cyc();
    prio_we = 0; prio_addr = '0; q_a1 = 5'd5;
    #1;
    tests++; if ({fwd_hit1, count, we3} !== {1'b0, 3'd1, 1'b0}) begin
      failed++; $display("FAIL kill_dead: got hit=%b cnt=%0d we3=%b need 0 1 0", fwd_hit1, count, we3); end
    cyc();
    #1;
    tests++; if ({empty, we3} !== 2'b10) begin
      failed++; $display("FAIL kill_pop: got empty=%b we3=%b need 1 0", empty, we3); end
    // A request enqueued on the same edge as a primary write to its address survives.
    prio_we = 1; prio_addr = 5'd9;
    in_valid = 1; in_addr = 5'd9; in_data = 32'h99;
    cyc();
    in_valid = 0; prio_we = 0; prio_addr = '0; q_a1 = 5'd9;
    #1;
    tests++; if ({fwd_hit1, fwd_data1, we3, a3} !== {1'b1, 32'h99, 1'b1, 5'd9}) begin
      failed++; $display("FAIL kill_young: got hit=%b d=%0h we3=%b a3=%0d need 1 99 1 9", fwd_hit1, fwd_data1, we3, a3); end
    cyc();
    q_a1 = '0;
  endtask

  task automatic test_x0();
    in_valid = 1; in_addr = '0; in_data = 32'hFFFF_FFFF; prio_we = 0;
    #1;
    tests++; if (in_ready !== 1'b1) begin
      failed++; $display("FAIL x0_ready: got %b need 1", in_ready); end
    cyc();
    in_valid = 0;
    #1;
    tests++; if ({count, we3} !== {3'd0, 1'b0}) begin
      failed++; $display("FAIL x0_nowrite: got cnt=%0d we3=%b need 0 0", count, we3); end
    cyc();
    #1;
    tests++; if (we3 !== 1'b0) begin
      failed++; $display("FAIL x0_later: got we3=%b need 0", we3); end
  endtask

  task automatic test_full_wrap();
    prio_we = 1; prio_addr = '0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_addr = 5'(i); in_data = 32'(10 + i);
      cyc();
    end
    prio_we = 0; in_valid = 1; in_addr = 5'd8; in_data = 32'd88;
    #1;
    tests++; if ({in_ready, we3, a3} !== {1'b0, 1'b1, 5'd1}) begin
      failed++; $display("FAIL full_block: got rdy=%b we3=%b a3=%0d need 0 1 1", in_ready, we3, a3); end
    cyc();
    #1;
    tests++; if ({count, in_ready} !== {3'd3, 1'b1}) begin
      failed++; $display("FAIL full_reopen: got cnt=%0d rdy=%b need 3 1", count, in_ready); end
    prio_we = 1;
    cyc();
    in_valid = 0; q_a1 = 5'd8;
    #1;
    tests++; if ({count, fwd_hit1, fwd_data1} !== {3'd4, 1'b1, 32'd88}) begin
      failed++; $display("FAIL full_wrap: got cnt=%0d hit=%b d=%0d need 4 1 88", count, fwd_hit1, fwd_data1); end
    prio_we = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (a3 !== ((i < 3) ? 5'(i + 2) : 5'd8) || we3 !== 1'b1) begin
        failed++; $display("FAIL wrap_drain_%0d: got a3=%0d we3=%b need %0d 1", i, a3, we3, (i < 3) ? i + 2 : 8); end
      cyc();
    end
    q_a1 = '0;
  endtask

  task automatic test_async_reset();
    prio_we = 1; prio_addr = '0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_addr = 5'(6 + i); in_data = 32'(100 + i);
      cyc();
    end
    in_valid = 0; prio_we = 0; q_a1 = 5'd6; q_a2 = 5'd8;
    #1;
    tests++; if ({we3, count, fwd_hit1, fwd_hit2} !== {1'b1, 3'd3, 1'b1, 1'b1}) begin
      failed++; $display("FAIL arst_pre: got we3=%b cnt=%0d hit=%b%b need 1 3 11", we3, count, fwd_hit1, fwd_hit2); end
    #1 rst_n = 0;
    mq.delete();
    #1;
    tests++; if ({we3, count, fwd_hit1, fwd_hit2, empty} !== {1'b0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      failed++; $display("FAIL arst_now: got we3=%b cnt=%0d hit=%b%b empty=%b need 0 0 00 1", we3, count, fwd_hit1, fwd_hit2, empty); end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if ({we3, count} !== {1'b0, 3'd0}) begin
        failed++; $display("FAIL arst_stale_%0d: got we3=%b cnt=%0d need 0 0", i, we3, count); end
      cyc();
    end
    q_a1 = '0; q_a2 = '0;
  endtask

  task automatic test_random();
    logic [108:0] got, exp;
    idle_inputs();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_addr   = 5'($urandom_range(0, 7));
      in_data   = $urandom;
      prio_we   = ($urandom_range(0, 3) == 0);
      prio_addr = 5'($urandom_range(0, 7));
      q_a1      = 5'($urandom_range(0, 7));
      q_a2      = 5'($urandom_range(0, 7));
      #1;
      model_outs();
      got = {we3, a3, di3, in_ready, count, empty, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2};
      exp = {e_we3, e_a3, e_di3, e_ready, e_count, e_empty, e_hit1, e_d1, e_hit2, e_d2};
      tests++; if (got !== exp) begin
        failed++; $display("FAIL rand_cyc%0d: got %h need %h", n, got, exp); end
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_latency();
    test_fill_order();
    test_kill();
    test_x0();
    test_full_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
